fetch_unit: RTL and testbench

Instruction fetch stage that drives the `pcOut`/`instWord` pair consumed by `Controller`, the producer end of the decode interface. It owns the fetch PC, issues word reads to a synchronous instruction memory with one-cycle latency, and buffers returned words in a small queue. It presents them to the decoder with a valid/ready handshake. Taken branches from the decoder (`enBranch`/`pcNext`) redirect it and squash wrong-path words.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0040;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} entries.
// Flush empties the queue; an entry popped in the flush cycle still leaves
// normally, so the pointers skip past it.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  // Storage and pointer update; flush wins over push.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= rd_ptr + PW'(pop);
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to a
// one-cycle-latency instruction memory, queues the returned words and hands
// them to the decoder over a valid/ready handshake. A taken branch
// (redirect) flushes the wrong path and restarts at the aligned target.
// Optional build macro FETCH_STATS_EN adds push and squash counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pcOut,
  output logic [INST_W-1:0] instWord,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_squashed
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int DW = CW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              squash;
  logic              pop;
  logic              push;
  logic              drop;
  logic [CW-1:0]     occupancy;
  logic [DW-1:0]     demand;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  assign pop = out_valid & out_ready;

  // Slots already claimed: queued words plus the response landing this cycle,
  // less the one leaving now. Issuing only below depth means no overflow.
  assign demand   = {1'b0, occupancy} + DW'(inflight) - DW'(pop);
  assign imem_req = ~reset & ~redirect & (demand < DW'(QUEUE_DEPTH));
  assign imem_addr = fetch_pc;

  // A response arriving in a redirect cycle is wrong-path. The squash flag
  // also covers the cycle after a redirect; request gating keeps that slot
  // empty today, but the flag keeps it safe if the gating ever changes.
  assign drop      = inflight & (redirect | squash);
  assign push      = inflight & ~redirect & ~squash;
  assign push_data = '{pc: inflight_pc, inst: imem_data};

  // Fetch PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      inflight <= imem_req;
      squash   <= redirect;
      if (imem_req) inflight_pc <= fetch_pc;
      if (redirect)      fetch_pc <= redirect_pc & ~32'h3;
      else if (imem_req) fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .head_valid(out_valid),
    .count     (occupancy)
  );

  assign pcOut    = head.pc;
  assign instWord = head.inst;

`ifdef FETCH_STATS_EN
  logic [CW-1:0] flushed;
  assign flushed = redirect ? (occupancy - CW'(pop)) : '0;

  // Push and squash counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched  <= '0;
      stat_squashed <= '0;
    end else begin
      stat_fetched  <= stat_fetched + 32'(push);
      stat_squashed <= stat_squashed + 32'(drop) + 32'(flushed);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference model tracks the program
// order stream: a list of outstanding fetched PCs with their request cycles.
module tb_fetch_unit;

  localparam logic [31:0] K     = 32'hA5A5_0000;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h40;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] pcOut;
  logic [31:0] instWord;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        w_reset = 1'b1;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data = '0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_squashed, w_stat_fetched, w_stat_squashed;
`endif

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .out_valid(out_valid), .out_ready(out_ready),
    .pcOut(pcOut), .instWord(instWord), .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_squashed(stat_squashed)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_data(w_data), .out_valid(w_valid), .out_ready(w_ready),
    .pcOut(w_pc), .instWord(w_inst), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(w_stat_fetched), .stat_squashed(w_stat_squashed)
`endif
  );

  // Instruction memories: one-cycle read latency, junk when not requested.
  always @(posedge clk) imem_data <= imem_req ? (imem_addr ^ K) : $urandom;
  always @(posedge clk) w_data    <= w_req ? (w_addr ^ K) : $urandom;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] q_pc[$];
  int          q_cyc[$];
  logic [31:0] next_pc = RPC;
  int          cyc = 0;
  int          squashed_m = 0;
  logic        e_valid, e_req, pop_m;
  logic [31:0] e_pc, e_inst, e_addr;

  task automatic expect_now();
    #1;
    e_valid = (q_pc.size() > 0) && (q_cyc[0] <= cyc - 2);
    e_pc    = e_valid ? q_pc[0] : 32'h0;
    e_inst  = e_pc ^ K;
    pop_m   = e_valid && out_ready;
    e_req   = !reset && !redirect && ((q_pc.size() - int'(pop_m)) < DEPTH);
    e_addr  = next_pc;
  endtask

  task automatic advance();
    if (reset) begin
      q_pc.delete(); q_cyc.delete();
      next_pc = RPC; squashed_m = 0;
    end else begin
      if (pop_m) begin void'(q_pc.pop_front()); void'(q_cyc.pop_front()); end
      if (redirect) begin
        squashed_m += q_pc.size();
        q_pc.delete(); q_cyc.delete();
        next_pc = {redirect_pc[31:2], 2'b00};
      end else if (e_req) begin
        q_pc.push_back(next_pc); q_cyc.push_back(cyc);
        next_pc += 32'd4;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; out_ready = 1'b1; redirect = 1'b0;
    repeat (n) begin expect_now(); advance(); end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; redirect = 1'b0;
    expect_now(); advance();
    for (int i = 0; i < 3; i++) begin
      expect_now();
      vectors++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0 || pcOut !== 32'h0 || instWord !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_hold: got valid=%b req=%b pc=%h inst=%h want 0/0/0/0", out_valid, imem_req, pcOut, instWord);
      end
      advance();
    end
    reset = 1'b0;
    expect_now();
    vectors++;
    if (out_valid !== 1'b0 || pcOut !== 32'h0 || instWord !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release_out: got valid=%b pc=%h inst=%h want 0/0/0", out_valid, pcOut, instWord);
    end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      miscompares++;
      $display("FAIL reset_first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC);
    end
    advance();
  endtask

  task automatic test_stream();
    int first_req = -1, first_valid = -1, valid_cnt = 0;
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      expect_now();
      vectors++;
      if (out_valid !== e_valid) begin miscompares++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        vectors++;
        if (pcOut !== e_pc || instWord !== e_inst) begin miscompares++; $display("FAIL stream_head c%0d: got %h/%h want %h/%h", cyc, pcOut, instWord, e_pc, e_inst); end
      end
      vectors++;
      if (imem_req !== e_req) begin miscompares++; $display("FAIL stream_req c%0d: got %b want %b", cyc, imem_req, e_req); end
      if (e_req) begin
        vectors++;
        if (imem_addr !== e_addr) begin miscompares++; $display("FAIL stream_addr c%0d: got %h want %h", cyc, imem_addr, e_addr); end
      end
      if (imem_req === 1'b1 && first_req < 0) first_req = i;
      if (out_valid === 1'b1 && first_valid < 0) first_valid = i;
      if (out_valid === 1'b1) valid_cnt++;
      advance();
    end
    vectors++;
    if (first_req != 0 || first_valid != 2) begin
      miscompares++;
      $display("FAIL stream_latency: got req@%0d valid@%0d want req@0 valid@2", first_req, first_valid);
    end
    vectors++;
    if (valid_cnt != 14) begin
      miscompares++;
      $display("FAIL stream_throughput: got %0d valid cycles want 14", valid_cnt);
    end
  endtask

  task automatic test_stall();
    logic [31:0] got[$];
    bit seen = 0;
    int stall_cnt = 0;
    do_reset(2);
    for (int i = 0; i < 24; i++) begin
      out_ready = 1'b1;
      expect_now();
      if (e_valid) seen = 1;
      out_ready = !(seen && stall_cnt < 10);
      expect_now();
      vectors++;
      if (out_valid !== e_valid) begin miscompares++; $display("FAIL stall_valid c%0d: got %b want %b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        vectors++;
        if (pcOut !== e_pc || instWord !== e_inst) begin miscompares++; $display("FAIL stall_head c%0d: got %h/%h want %h/%h", cyc, pcOut, instWord, e_pc, e_inst); end
      end
      vectors++;
      if (imem_req !== e_req) begin miscompares++; $display("FAIL stall_req c%0d: got %b want %b", cyc, imem_req, e_req); end
      if (e_req) begin
        vectors++;
        if (imem_addr !== e_addr) begin miscompares++; $display("FAIL stall_addr c%0d: got %h want %h", cyc, imem_addr, e_addr); end
      end
      if (seen && stall_cnt == 9) begin
        vectors++;
        if (out_valid !== 1'b1 || imem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_full: got valid=%b req=%b want 1/0", out_valid, imem_req);
        end
      end
      if (out_valid === 1'b1 && out_ready) got.push_back(pcOut);
      if (seen) stall_cnt++;
      advance();
    end
    vectors++;
    if (got.size() < 3 || got[0] !== 32'h40 || got[1] !== 32'h44 || got[2] !== 32'h48) begin
      miscompares++;
      $display("FAIL stall_order: got %0d items first=%h want 40,44,48", got.size(), (got.size() > 0) ? got[0] : 32'h0);
    end
  endtask

  task automatic test_redirect();
    bit fired = 0, bad = 0;
    int r = -10;
    do_reset(2);
    for (int i = 0; i < 14; i++) begin
      redirect = 1'b0;
      expect_now();
      if (!fired && e_valid && e_pc == 32'h44) begin
        redirect = 1'b1; redirect_pc = 32'h100; fired = 1; r = i;
        expect_now();
      end
      vectors++;
      if (out_valid !== e_valid) begin miscompares++; $display("FAIL redir_valid c%0d: got %b want %b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        vectors++;
        if (pcOut !== e_pc || instWord !== e_inst) begin miscompares++; $display("FAIL redir_head c%0d: got %h/%h want %h/%h", cyc, pcOut, instWord, e_pc, e_inst); end
      end
      vectors++;
      if (imem_req !== e_req) begin miscompares++; $display("FAIL redir_req c%0d: got %b want %b", cyc, imem_req, e_req); end
      if (e_req) begin
        vectors++;
        if (imem_addr !== e_addr) begin miscompares++; $display("FAIL redir_addr c%0d: got %h want %h", cyc, imem_addr, e_addr); end
      end
      if (i == r + 3) begin
        vectors++;
        if (out_valid !== 1'b1 || pcOut !== 32'h100) begin
          miscompares++;
          $display("FAIL redir_target: got valid=%b pc=%h want 1/00000100", out_valid, pcOut);
        end
      end
      if (out_valid === 1'b1 && (pcOut === 32'h48 || pcOut === 32'h4C)) bad = 1;
      advance();
    end
    redirect = 1'b0;
    vectors++;
    if (!fired || bad) begin
      miscompares++;
      $display("FAIL redir_wrongpath: got fired=%b wrongpath_seen=%b want 1/0", fired, bad);
    end
`ifdef FETCH_STATS_EN
    vectors++;
    if (stat_squashed !== 32'(squashed_m)) begin
      miscompares++;
      $display("FAIL redir_stat_squashed: got %0d want %0d", stat_squashed, squashed_m);
    end
`endif
  endtask

  task automatic test_redirect_misc();
    logic [31:0] first_after = '0;
    bit got_first = 0;
    do_reset(2);
    for (int i = 0; i < 18; i++) begin
      redirect = 1'b0;
      case (i)
        3: begin redirect = 1'b1; redirect_pc = 32'h203; end
        8: begin redirect = 1'b1; redirect_pc = 32'h300; end
        9: begin redirect = 1'b1; redirect_pc = 32'h400; end
        default: ;
      endcase
      expect_now();
      vectors++;
      if (out_valid !== e_valid) begin miscompares++; $display("FAIL misc_valid c%0d: got %b want %b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        vectors++;
        if (pcOut !== e_pc || instWord !== e_inst) begin miscompares++; $display("FAIL misc_head c%0d: got %h/%h want %h/%h", cyc, pcOut, instWord, e_pc, e_inst); end
      end
      vectors++;
      if (imem_req !== e_req) begin miscompares++; $display("FAIL misc_req c%0d: got %b want %b", cyc, imem_req, e_req); end
      if (e_req) begin
        vectors++;
        if (imem_addr !== e_addr) begin miscompares++; $display("FAIL misc_addr c%0d: got %h want %h", cyc, imem_addr, e_addr); end
      end
      if (i == 4) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
          miscompares++;
          $display("FAIL misc_align: got req=%b addr=%h want 1/00000200", imem_req, imem_addr);
        end
      end
      if (i >= 9 && !got_first && out_valid === 1'b1) begin first_after = pcOut; got_first = 1; end
      advance();
    end
    redirect = 1'b0;
    vectors++;
    if (!got_first || first_after !== 32'h400) begin
      miscompares++;
      $display("FAIL misc_b2b: got %h want 00000400", first_after);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] first_after = '0;
    bit got_first = 0;
    do_reset(2);
    for (int i = 0; i < 14; i++) begin
      out_ready = (i < 2) || (i > 4);
      reset = (i == 3);
      expect_now();
      vectors++;
      if (out_valid !== e_valid) begin miscompares++; $display("FAIL rmid_valid c%0d: got %b want %b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        vectors++;
        if (pcOut !== e_pc || instWord !== e_inst) begin miscompares++; $display("FAIL rmid_head c%0d: got %h/%h want %h/%h", cyc, pcOut, instWord, e_pc, e_inst); end
      end
      vectors++;
      if (imem_req !== e_req) begin miscompares++; $display("FAIL rmid_req c%0d: got %b want %b", cyc, imem_req, e_req); end
      if (e_req) begin
        vectors++;
        if (imem_addr !== e_addr) begin miscompares++; $display("FAIL rmid_addr c%0d: got %h want %h", cyc, imem_addr, e_addr); end
      end
      if (i == 4) begin
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_cleared: got valid=%b want 0", out_valid); end
      end
      if (i > 4 && !got_first && out_valid === 1'b1) begin first_after = pcOut; got_first = 1; end
      advance();
    end
    reset = 1'b0;
    vectors++;
    if (!got_first || first_after !== 32'h40) begin
      miscompares++;
      $display("FAIL rmid_resume: got %h want 00000040", first_after);
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = $urandom;
      reset       = ($urandom_range(0, 999) < 3);
      expect_now();
      vectors++;
      if (out_valid !== e_valid) begin miscompares++; $display("FAIL rand_valid c%0d: got %b want %b", cyc, out_valid, e_valid); end
      if (e_valid) begin
        vectors++;
        if (pcOut !== e_pc || instWord !== e_inst) begin miscompares++; $display("FAIL rand_head c%0d: got %h/%h want %h/%h", cyc, pcOut, instWord, e_pc, e_inst); end
      end
      vectors++;
      if (imem_req !== e_req) begin miscompares++; $display("FAIL rand_req c%0d: got %b want %b", cyc, imem_req, e_req); end
      if (e_req) begin
        vectors++;
        if (imem_addr !== e_addr) begin miscompares++; $display("FAIL rand_addr c%0d: got %h want %h", cyc, imem_addr, e_addr); end
      end
      advance();
    end
    reset = 1'b0; redirect = 1'b0;
`ifdef FETCH_STATS_EN
    expect_now();
    vectors++;
    if (stat_squashed !== 32'(squashed_m)) begin
      miscompares++;
      $display("FAIL rand_stat_squashed: got %0d want %0d", stat_squashed, squashed_m);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    logic [31:0] want[3];
    reset = 1'b1;
    w_reset = 1'b1; w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    w_reset = 1'b0;
    want[0] = 32'hFFFF_FFFC; want[1] = 32'h0; want[2] = 32'h4;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 0) begin
        vectors++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
          miscompares++;
          $display("FAIL wrap_first_req: got req=%b addr=%h want 1/fffffffc", w_req, w_addr);
        end
      end
      if (w_valid === 1'b1 && got.size() < 3) begin
        vectors++;
        if (w_pc !== want[got.size()] || w_inst !== (want[got.size()] ^ K)) begin
          miscompares++;
          $display("FAIL wrap_seq[%0d]: got %h/%h want %h/%h", got.size(), w_pc, w_inst, want[got.size()], want[got.size()] ^ K);
        end
        got.push_back(w_pc);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d deliveries want 3", got.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_misc();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
